player_controller: RTL

//   Drives the player_physics block: sequences game_tick phases per frame, issues the
//   one-cycle jump_pulse, qualifies button_down, and consumes jump_done to end a jump.

---
 rtl/player_controller_pkg.sv | 22 ++
 rtl/player_controller_button_debounce.sv | 41 ++++
 rtl/player_controller.sv | 88 ++++++++
 3 files changed

// File: rtl/player_controller_pkg.sv
// Shared encodings for the player controller: player state and game_tick phase codes.
package player_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_JUMP = 2'b10,
        ST_DEAD = 2'b11
    } player_state_t;

    typedef enum logic [1:0] {
        GT_NONE = 2'b00,
        GT_VEL  = 2'b01,
        GT_POS  = 2'b10
    } game_tick_t;

    // Ticks and the down request only reach physics while the player is in play.
    function automatic logic is_active(input player_state_t s);
        return (s == ST_RUN) || (s == ST_JUMP);
    endfunction

endpackage

// File: rtl/player_controller_button_debounce.sv
// Two-flop synchroniser followed by a stability counter; the level follows the
// synchronised input only after it has held a new value for DEBOUNCE_CYCLES cycles.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEBOUNCE_W      = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level
);

    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

    logic                  sync_q1;
    logic                  sync_q2;
    logic [DEBOUNCE_W-1:0] stable_cnt;

    // NOTE: non-blocking assignments make every flop sample pre-edge values; with
    // blocking ones the two synchroniser stages would collapse into a single flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_q2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_controller.sv
// Player FSM, per-frame velocity/position tick sequencer and output qualification
// feeding player_physics.
module player_controller
    import player_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEBOUNCE_W      = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic       collision,
    input  logic       game_restart,
    input  logic       jump_done,
    output logic [1:0] game_tick,
    output logic       jump_pulse,
    output logic       button_down,
    output logic [1:0] player_state
);

    player_state_t state;
    game_tick_t    phase;
    logic          dbnc_up;
    logic          dbnc_down;
    logic          up_prev;
    logic          up_rise;
    logic          jump_fire;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEBOUNCE_W     (DEBOUNCE_W)
    ) u_dbnc_up (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_raw(btn_up_raw),
        .level  (dbnc_up)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEBOUNCE_W     (DEBOUNCE_W)
    ) u_dbnc_down (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_raw(btn_down_raw),
        .level  (dbnc_down)
    );

    // A held up button after DEAD->IDLE must not restart the run; only a fresh press does.
    assign up_rise   = dbnc_up & ~up_prev;
    assign jump_fire = (phase == GT_VEL) && (state == ST_RUN) && dbnc_up && !dbnc_down;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            phase   <= GT_NONE;
            up_prev <= 1'b0;
        end else begin
            up_prev <= dbnc_up;
            if (collision && (state != ST_DEAD)) begin
                state <= ST_DEAD;
                phase <= GT_NONE;
            end else begin
                unique case (state)
                    ST_IDLE: if (up_rise)                          state <= ST_RUN;
                    ST_RUN:  if (jump_fire)                        state <= ST_JUMP;
                    ST_JUMP: if ((phase == GT_POS) && jump_done)   state <= ST_RUN;
                    ST_DEAD: if (game_restart)                     state <= ST_IDLE;
                    default:                                       state <= ST_IDLE;
                endcase
                // A frame_tick landing inside a running sequence is dropped.
                unique case (phase)
                    GT_VEL:  phase <= GT_POS;
                    GT_POS:  phase <= GT_NONE;
                    default: phase <= (frame_tick && is_active(state)) ? GT_VEL : GT_NONE;
                endcase
            end
        end
    end

    assign game_tick    = phase;
    assign player_state = state;
    assign jump_pulse   = jump_fire;
    assign button_down  = dbnc_down && is_active(state);

endmodule
